// File: rtl/gpio_debounce.sv
// gpio_debounce: per-channel synchroniser, debouncer, edge pulses and sticky
// edge capture with a masked level interrupt, feeding a PIO in_port.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   raw_in           asynchronous pin levels
//   clear_edges      per-bit synchronous clear of edge_capture
//   irq_mask         per-bit interrupt enable
//   clean_out        debounced registered level
//   rise_pulse       one-cycle pulse on an accepted 0->1 change
//   fall_pulse       one-cycle pulse on an accepted 1->0 change
//   edge_capture     sticky edge flags (edge chosen by EDGE_TYPE)
//   irq              registered OR of edge_capture & irq_mask
module gpio_debounce #(
    parameter int WIDTH           = 2,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RESET_LEVEL     = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] clear_edges,
    input  logic [WIDTH-1:0] irq_mask,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
);

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_SETTLING = 1'b1;

    localparam logic [WIDTH-1:0] RST_VEC =
        (RESET_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] edge_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RST_VEC;
            sync2 <= RST_VEC;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [0:0]       state;
        logic [CNT_W-1:0] cnt;
        logic             clean_q;
        logic             rise_q;
        logic             fall_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state   <= ST_STABLE;
                cnt     <= '0;
                clean_q <= RST_VEC[i];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                unique case (state)
                    ST_STABLE: begin
                        cnt <= '0;
                        if (sync2[i] != clean_q)
                            state <= ST_SETTLING;
                    end
                    ST_SETTLING: begin
                        if (sync2[i] == clean_q) begin
                            // bounce: drop back and requalify from scratch
                            state <= ST_STABLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            clean_q <= sync2[i];
                            rise_q  <= sync2[i];
                            fall_q  <= ~sync2[i];
                            state   <= ST_STABLE;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign clean_out[i]  = clean_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
    end

    always_comb begin
        edge_sel = rise_pulse;
        if (EDGE_TYPE == 1)
            edge_sel = fall_pulse;
        else if (EDGE_TYPE == 2)
            edge_sel = rise_pulse | fall_pulse;
    end

    // a new edge takes priority over a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irq          <= 1'b0;
        end else begin
            edge_capture <= (edge_capture & ~clear_edges) | edge_sel;
            irq          <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: directed and randomized checks of gpio_debounce
// against a streak-counting reference model (D=4, rising edge capture).
module tb_gpio_debounce;

    localparam int W = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] clear_edges;
    logic [W-1:0] irq_mask;
    logic [W-1:0] clean_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic [W-1:0] edge_capture;
    logic         irq;

    always #5 clk = ~clk;

    gpio_debounce #(
        .WIDTH(W), .CNT_W(16), .DEBOUNCE_CYCLES(D),
        .RESET_LEVEL(0), .EDGE_TYPE(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
        .clear_edges(clear_edges), .irq_mask(irq_mask),
        .clean_out(clean_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .edge_capture(edge_capture), .irq(irq)
    );

    int n_tot  = 0;
    int n_fail = 0;
    int rise_cnt [W];
    int fall_cnt [W];

    // reference model: raw delayed two samples, then a level is accepted
    // once D+1 consecutive delayed samples disagree with the current level
    logic [W-1:0] m_dly [$];
    logic [W-1:0] m_clean, m_rise, m_fall, m_edge;
    logic         m_irq;
    int           streak [W];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tot++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dly = {};
        m_dly.push_back('0);
        m_dly.push_back('0);
        m_clean = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_edge  = '0;
        m_irq   = 1'b0;
        for (int i = 0; i < W; i++) streak[i] = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] s;
        logic [W-1:0] nr, nf;
        s = m_dly.pop_front();
        m_dly.push_back(raw_in);
        nr = '0;
        nf = '0;
        for (int i = 0; i < W; i++) begin
            if (s[i] != m_clean[i]) begin
                streak[i]++;
                if (streak[i] == D + 1) begin
                    nr[i] = s[i];
                    nf[i] = ~s[i];
                    streak[i] = 0;
                end
            end else begin
                streak[i] = 0;
            end
        end
        m_irq   = |(m_edge & irq_mask);
        m_edge  = (m_edge & ~clear_edges) | m_rise;
        m_clean = m_clean ^ (nr | nf);
        m_rise  = nr;
        m_fall  = nf;
    endtask

    task automatic compare_all();
        check("cyc_clean", 32'(clean_out), 32'(m_clean));
        check("cyc_rise", 32'(rise_pulse), 32'(m_rise));
        check("cyc_fall", 32'(fall_pulse), 32'(m_fall));
        check("cyc_edge", 32'(edge_capture), 32'(m_edge));
        check("cyc_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        else model_reset();
        #1;
        for (int i = 0; i < W; i++) begin
            rise_cnt[i] += int'(rise_pulse[i]);
            fall_cnt[i] += int'(fall_pulse[i]);
        end
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic zero_counts();
        for (int i = 0; i < W; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
    endtask

    initial begin
        int hold;
        reset_n     = 1'b0;
        raw_in      = 2'b11;
        clear_edges = '0;
        irq_mask    = '0;
        model_reset();
        zero_counts();

        // reset, then release with both inputs high
        ticks(3);
        check("rst_clean", 32'(clean_out), 32'h0);
        check("rst_edge", 32'(edge_capture), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        ticks(6);
        check("rel_e6", 32'(clean_out), 32'h0);
        tick();
        check("rel_e7", 32'(clean_out), 32'h3);
        check("rel_rise", 32'(rise_pulse), 32'h3);
        tick();
        check("rel_rise_end", 32'(rise_pulse), 32'h0);

        // release both: fall on ch1 must not set rising edge capture
        clear_edges = 2'b11;
        tick();
        clear_edges = '0;
        check("clr_all", 32'(edge_capture), 32'h0);
        zero_counts();
        raw_in = 2'b00;
        ticks(9);
        check("fall1_cnt", 32'(fall_cnt[1]), 32'd1);
        check("fall_noedge", 32'(edge_capture), 32'h0);

        // clean press on ch0 with irq enabled
        irq_mask = 2'b01;
        raw_in   = 2'b01;
        ticks(6);
        check("press_e6", 32'(clean_out[0]), 32'h0);
        tick();
        check("press_e7", 32'(clean_out[0]), 32'h1);
        check("press_rise", 32'(rise_pulse), 32'h1);
        tick();
        check("press_edge", 32'(edge_capture), 32'h1);
        check("press_irq0", 32'(irq), 32'h0);
        tick();
        check("press_irq1", 32'(irq), 32'h1);

        // set/clear collision, then a plain clear
        raw_in = 2'b00;
        ticks(9);
        clear_edges = 2'b01;
        tick();
        clear_edges = '0;
        raw_in = 2'b01;
        ticks(7);
        check("coll_rise", 32'(rise_pulse[0]), 32'h1);
        clear_edges = 2'b01;
        tick();
        check("coll_set", 32'(edge_capture[0]), 32'h1);
        clear_edges = '0;
        tick();
        clear_edges = 2'b01;
        tick();
        clear_edges = '0;
        check("clr_edge", 32'(edge_capture[0]), 32'h0);
        check("clr_irq_lag", 32'(irq), 32'h1);
        tick();
        check("clr_irq", 32'(irq), 32'h0);

        // bounce rejection on ch0
        raw_in = 2'b00;
        ticks(9);
        zero_counts();
        for (int b = 0; b < 2; b++) begin
            raw_in = 2'b01;
            ticks(2);
            raw_in = 2'b00;
            ticks(2);
        end
        check("bnc_none", 32'(rise_cnt[0]), 32'd0);
        raw_in = 2'b01;
        ticks(6);
        check("bnc_e6", 32'(clean_out[0]), 32'h0);
        tick();
        check("bnc_e7", 32'(clean_out[0]), 32'h1);
        ticks(3);
        check("bnc_once", 32'(rise_cnt[0]), 32'd1);

        // reset two cycles into settling
        raw_in = 2'b00;
        ticks(9);
        zero_counts();
        raw_in = 2'b01;
        ticks(5);
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("mid_clean", 32'(clean_out), 32'h0);
        ticks(2);
        reset_n = 1'b1;
        ticks(6);
        check("mid_e6", 32'(clean_out[0]), 32'h0);
        check("mid_nopulse", 32'(rise_cnt[0]), 32'd0);
        tick();
        check("mid_e7", 32'(clean_out[0]), 32'h1);
        check("mid_once", 32'(rise_cnt[0]), 32'd1);

        // randomized bouncing, clears and masks against the model
        for (int s = 0; s < 80; s++) begin
            raw_in   = 2'($urandom);
            irq_mask = 2'($urandom);
            hold     = $urandom_range(1, D + 5);
            for (int c = 0; c < hold; c++) begin
                clear_edges = ($urandom_range(0, 7) == 0) ? 2'($urandom) : '0;
                tick();
            end
        end
        clear_edges = '0;
        ticks(10);

        $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
        $finish;
    end

endmodule

// File: doc/gpio_debounce.md
Name: gpio_debounce

Overview:
- Per-channel input conditioner that sits directly upstream of the 2-bit Avalon PIO input port; its clean_out drives that port's in_port.
- Synchronises asynchronous push-button/switch lines, rejects bounce shorter than DEBOUNCE_CYCLES, and emits single-cycle rise/fall pulses.
- Keeps sticky edge-capture flags with a level interrupt, so software can poll or take an interrupt instead of sampling raw levels.

Parameters:
- WIDTH, 2, number of independent input channels.
- CNT_W, 16, width of each channel's settle counter.
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a new level (1 ms at 50 MHz); legal range 1 to 2^CNT_W-1.
- RESET_LEVEL, 0, reset value applied to every bit of the synchroniser and clean_out.
- EDGE_TYPE, 0, edge that sets edge_capture: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- raw_in  input  WIDTH  asynchronous pin levels.
- clear_edges  input  WIDTH  per-bit synchronous clear of edge_capture.
- irq_mask  input  WIDTH  per-bit interrupt enable.
- clean_out  output  WIDTH  debounced level, registered.
- rise_pulse  output  WIDTH  one-cycle pulse on an accepted 0->1 transition.
- fall_pulse  output  WIDTH  one-cycle pulse on an accepted 1->0 transition.
- edge_capture  output  WIDTH  sticky edge flags.
- irq  output  1  OR-reduction of (edge_capture & irq_mask), registered.

Behaviour:
Reset (reset_n = 0, asynchronous):
- sync1, sync2 and clean_out go to {WIDTH{RESET_LEVEL}}.
- Pulses, edge_capture, irq and all counters go to 0; every channel FSM goes to STABLE.
- Reset asserted mid-settle discards the pending transition; no pulse is emitted.

Synchroniser:
- Two-flop chain per bit, raw_in -> sync1 -> sync2.
- Only sync2 feeds the FSM.

Per-channel FSM (each channel independent):
- STABLE: cnt held at 0. If sync2 != clean_out, go to SETTLING with cnt = 0.
- SETTLING, sync2 == clean_out: bounce rejected. Go to STABLE, cnt = 0, clean_out unchanged, no pulse.
- SETTLING, sync2 != clean_out and cnt < DEBOUNCE_CYCLES-1: cnt increments by 1.
- SETTLING, sync2 != clean_out and cnt == DEBOUNCE_CYCLES-1:
  - clean_out takes sync2.
  - rise_pulse or fall_pulse is asserted for exactly that one cycle (registered, aligned with the clean_out change).
  - Go to STABLE.
- cnt never wraps; it is bounded by the legal DEBOUNCE_CYCLES range.

Latency:
- A raw_in step that is held steady appears on clean_out DEBOUNCE_CYCLES+3 clk edges after the first edge that samples it.
- The breakdown is 2 synchroniser edges + 1 edge to enter SETTLING + DEBOUNCE_CYCLES counting edges.
- Any glitch in sync2 during SETTLING restarts the qualification from STABLE.

Edge capture:
- Bit i sets on the cycle after the selected pulse for channel i.
- Bit i clears on the cycle after clear_edges[i] = 1.
- If set and clear occur together, set wins and the bit stays 1.
- Bits are unaffected by irq_mask.

irq:
- irq = |(edge_capture & irq_mask), registered.
- Lags edge_capture by one cycle.

Simultaneous transitions on different channels are fully independent; no arbitration is needed.

Test Plan:
- Reset: hold reset_n = 0 with raw_in = 2'b11 and params D=4, RESET_LEVEL=0 -> clean_out = 0, edge_capture = 0, irq = 0. After release with raw_in held at 11, clean_out = 2'b11 at edge 7 and rise_pulse = 2'b11 for one cycle.
- Clean press (D=4): raw_in[0] steps 0->1 and is held -> clean_out[0] rises exactly 7 edges later. rise_pulse[0] is high for one cycle. edge_capture[0] = 1 the next cycle; with irq_mask = 2'b01, irq = 1 one cycle after that.
- Bounce rejection (D=4): raw_in[0] toggles 0,1,0,1 every 2 cycles, then is held at 1 -> no pulse during bouncing. clean_out[0] rises 7 edges after the final 0->1 step. Exactly one rise_pulse.
- Release, EDGE_TYPE=0: raw_in[1] steps 1->0 and is held -> fall_pulse[1] is asserted once. edge_capture[1] stays 0.
- Set/clear collision: drive clear_edges[0] = 1 in the same cycle that edge_capture[0] sets -> edge_capture[0] = 1. A further clear_edges pulse with no edge -> edge_capture[0] = 0, and irq drops one cycle later.
- Reset mid-settle (D=4): assert reset_n = 0 two cycles into SETTLING -> no pulse. clean_out returns to RESET_LEVEL, and the settle restarts from STABLE after release.
